// File: rtl/duv_arb_if.sv
// -----------------------------------------------------------------------------
// duv_arb_if
//   Bundles the requester-facing handshake, the duv mux drive and the
//   output tag of the round-robin arbiter.
//   master : requester / environment side (drives req/dat, observes the rest)
//   slave  : arbiter side (observes req/dat, drives grants, mux and tags)
//   Signals:
//     req0/req1        requests (level, held while owning)
//     dat0/dat1        requester data bits
//     gnt0/gnt1        ownership flags (registered)
//     mux_sel          duv.sel (registered)
//     mux_in0/mux_in1  duv.in0/duv.in1, data gated by the grant
//     out_vld/out_src  valid/source tag aligned with duv.out
//     gnt0_cnt/1_cnt   grant-entry counters (zero unless stats are built)
// -----------------------------------------------------------------------------
interface duv_arb_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req0;
    logic             dat0;
    logic             req1;
    logic             dat1;
    logic             gnt0;
    logic             gnt1;
    logic             mux_sel;
    logic             mux_in0;
    logic             mux_in1;
    logic             out_vld;
    logic             out_src;
    logic [CNT_W-1:0] gnt0_cnt;
    logic [CNT_W-1:0] gnt1_cnt;

    modport master (
        output req0, dat0, req1, dat1,
        input  gnt0, gnt1, mux_sel, mux_in0, mux_in1,
        input  out_vld, out_src, gnt0_cnt, gnt1_cnt
    );

    modport slave (
        input  req0, dat0, req1, dat1,
        output gnt0, gnt1, mux_sel, mux_in0, mux_in1,
        output out_vld, out_src, gnt0_cnt, gnt1_cnt
    );
endinterface

// File: rtl/duv_arb.sv
// -----------------------------------------------------------------------------
// duv_arb
//   Two-requester round-robin arbiter owning the select of the registered
//   2:1 mux (duv). Ownership is bounded to MAX_BURST consecutive cycles while
//   the other requester waits; the output tag tracks duv's 1-cycle latency.
//   Ports:
//     clk     single clock, rising edge
//     nreset  synchronous reset, active-high (name kept from the legacy block)
//     bus     duv_arb_if.slave: req/dat in; gnt, mux drive, out tag, counters
//   Parameters:
//     MAX_BURST  max consecutive owned cycles while the other side waits (>=1)
//     CNT_W      width of the grant counters
//   Configuration:
//     MUX_ARB_STATS_EN  when defined, gnt0_cnt/gnt1_cnt count entries into
//                       OWN0/OWN1 (saturating); otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module duv_arb #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       nreset,
    duv_arb_if.slave   bus
);
    localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    // One-hot owner encoding so each grant is a flop bit directly.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               last_q;
    logic               sel_q;
    logic               vld_q;
    logic               src_q;
    logic               own_req_c;
    logic               oth_req_c;
    logic [1:0]         oth_state_c;
    logic               enter_c;

    // Owner/other view of the requests for the current state.
    always_comb begin
        own_req_c   = 1'b0;
        oth_req_c   = 1'b0;
        oth_state_c = IDLE;
        if (state_q == OWN0) begin
            own_req_c   = bus.req0;
            oth_req_c   = bus.req1;
            oth_state_c = OWN1;
        end else if (state_q == OWN1) begin
            own_req_c   = bus.req1;
            oth_req_c   = bus.req0;
            oth_state_c = OWN0;
        end
    end

    // Next-state and burst tracking.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req_c) begin
                    state_d = oth_req_c ? oth_state_c : IDLE;
                end else if (oth_req_c && (burst_q == BURST_LAST)) begin
                    state_d = oth_state_c;
                end
            end
            default: state_d = IDLE;
        endcase

        // Burst only advances while the other side is kept waiting.
        if ((state_d != state_q) || !oth_req_c) begin
            burst_d = '0;
        end else if (burst_q != BURST_LAST) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    assign enter_c = (state_d != state_q) && (state_d != IDLE);

    // Round-robin pointer, mux select and output tag aligned to duv's register.
    always_ff @(posedge clk) begin
        if (nreset) begin
            last_q <= 1'b1;
            sel_q  <= 1'b0;
            vld_q  <= 1'b0;
            src_q  <= 1'b0;
        end else begin
            if (enter_c) begin
                last_q <= state_d[1];
                sel_q  <= state_d[1];
            end
            vld_q <= |state_q;
            src_q <= sel_q;
        end
    end

    assign bus.gnt0    = state_q[0];
    assign bus.gnt1    = state_q[1];
    assign bus.mux_sel = sel_q;
    assign bus.mux_in0 = bus.dat0 & state_q[0];
    assign bus.mux_in1 = bus.dat1 & state_q[1];
    assign bus.out_vld = vld_q;
    assign bus.out_src = src_q;

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating counts of entries into each ownership state.
    always_ff @(posedge clk) begin
        if (nreset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if ((state_d == OWN0) && (state_q != OWN0) && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if ((state_d == OWN1) && (state_q != OWN1) && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign bus.gnt0_cnt = cnt0_q;
    assign bus.gnt1_cnt = cnt1_q;
`else
    assign bus.gnt0_cnt = CNT_W'(0);
    assign bus.gnt1_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_duv_arb.sv
// -----------------------------------------------------------------------------
// tb_duv_arb
//   Self-checking bench for duv_arb (MAX_BURST=4, CNT_W=2) with a
//   behavioural reference model of ownership, round-robin and output tags.
// -----------------------------------------------------------------------------
module tb_duv_arb;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic nreset;

    duv_arb_if #(.CNT_W(CNT_W)) bus ();

    duv_arb #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner is -1 (nobody), 0 or 1.
    int m_owner;
    int m_last;
    int m_sel;
    int m_wait;     // cycles the current owner has held while the other waited
    int m_vld;
    int m_src;
    int m_cnt0;
    int m_cnt1;
    bit cur_d0;
    bit cur_d1;

`ifdef MUX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic model_edge(input bit rst, input bit r0, input bit r1);
        int nxt;
        int nv;
        int ns;
        bit req [2];
        req[0] = r0;
        req[1] = r1;
        if (rst) begin
            m_owner = -1; m_last = 1; m_sel = 0; m_wait = 0;
            m_vld = 0; m_src = 0; m_cnt0 = 0; m_cnt1 = 0;
            return;
        end
        nv = (m_owner >= 0) ? 1 : 0;
        ns = m_sel;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
        end else begin
            int other = 1 - m_owner;
            if (!req[m_owner])                             nxt = req[other] ? other : -1;
            else if (req[other] && m_wait + 1 >= MAX_BURST) nxt = other;
        end
        if (nxt != m_owner) begin
            m_wait = 0;
            if (nxt >= 0) begin
                m_last = nxt;
                m_sel  = nxt;
                if (nxt == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
                if (nxt == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
            end
        end else if (nxt >= 0) begin
            if (req[1 - nxt]) m_wait = (m_wait + 1 < MAX_BURST) ? m_wait + 1 : MAX_BURST - 1;
            else              m_wait = 0;
        end
        m_owner = nxt;
        m_vld   = nv;
        m_src   = ns;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle after.
    task automatic cycle(input bit rst, input bit r0, input bit d0, input bit r1, input bit d1);
        nreset   = rst;
        bus.req0 = r0;
        bus.dat0 = d0;
        bus.req1 = r1;
        bus.dat1 = d1;
        cur_d0   = d0;
        cur_d1   = d1;
        @(posedge clk);
        model_edge(rst, r0, r1);
        #1;
    endtask

    task automatic test_reset;
        cycle(1, 1, 1, 1, 1);
        cycle(1, 0, 0, 0, 0);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got gnt0=%b gnt1=%b expected 0 0", bus.gnt0, bus.gnt1);
        end
        checks++;
        if (bus.mux_sel !== 1'b0 || bus.out_vld !== 1'b0 || bus.out_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got sel=%b vld=%b src=%b expected 0 0 0",
                     bus.mux_sel, bus.out_vld, bus.out_src);
        end
        checks++;
        if (bus.gnt0_cnt !== '0 || bus.gnt1_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d expected 0 0", bus.gnt0_cnt, bus.gnt1_cnt);
        end
    endtask

    task automatic test_single;
        cycle(0, 1, 1, 0, 0);
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mux_in0 !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: got gnt0=%b gnt1=%b in0=%b expected 1 0 1",
                     bus.gnt0, bus.gnt1, bus.mux_in0);
        end
        cycle(0, 1, 1, 0, 0);
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_src !== 1'b0) begin
            errors++;
            $display("FAIL single_tag: got vld=%b src=%b expected 1 0", bus.out_vld, bus.out_src);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got gnt0=%b vld=%b expected 0 0", bus.gnt0, bus.out_vld);
        end
    endtask

    task automatic test_tie;
        int bad;
        int bad_sel;
        cycle(1, 0, 0, 0, 0);
        bad = 0;
        bad_sel = 0;
        for (int k = 0; k < 16; k++) begin
            bit exp0;
            cycle(0, 1, 0, 1, 0);
            exp0 = (((k / MAX_BURST) % 2) == 0);
            if (bus.gnt0 !== exp0 || bus.gnt1 !== !exp0) bad++;
            if (bus.mux_sel !== !exp0) bad_sel++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tie_pattern: got %0d wrong grant cycles expected 0", bad);
        end
        checks++;
        if (bad_sel != 0) begin
            errors++;
            $display("FAIL tie_sel: got %0d wrong select cycles expected 0", bad_sel);
        end
    endtask

    task automatic test_handover;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 1, 0, 0);
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.out_src !== 1'b1) begin
            errors++;
            $display("FAIL handover_gnt: got gnt0=%b gnt1=%b src=%b expected 1 0 1",
                     bus.gnt0, bus.gnt1, bus.out_src);
        end
        cycle(0, 0, 0, 1, 1);
        checks++;
        if (bus.out_src !== 1'b0 || bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL handover_src: got src=%b gnt1=%b expected 0 1", bus.out_src, bus.gnt1);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.mux_sel !== 1'b1) begin
            errors++;
            $display("FAIL handover_idle: got gnt0=%b gnt1=%b sel=%b expected 0 0 1",
                     bus.gnt0, bus.gnt1, bus.mux_sel);
        end
    endtask

    task automatic test_reset_mid;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 0);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: got gnt0=%b gnt1=%b expected 0 0", bus.gnt0, bus.gnt1);
        end
        cycle(0, 1, 0, 1, 0);
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_winner: got gnt0=%b gnt1=%b expected 1 0", bus.gnt0, bus.gnt1);
        end
    endtask

    task automatic test_stats;
        int exp0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 1, 0);
        exp0 = STATS ? 3 : 0;
        checks++;
        if (int'(bus.gnt0_cnt) != exp0) begin
            errors++;
            $display("FAIL stats_cnt0: got %0d expected %0d", bus.gnt0_cnt, exp0);
        end
        checks++;
        if (int'(bus.gnt1_cnt) != (STATS ? 1 : 0)) begin
            errors++;
            $display("FAIL stats_cnt1: got %0d expected %0d", bus.gnt1_cnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_random;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit rst;
            rst = ($urandom_range(0, 59) == 0);
            cycle(rst, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (bus.gnt0 !== (m_owner == 0) || bus.gnt1 !== (m_owner == 1)) begin
                errors++;
                $display("FAIL rand_gnt @%0d: got %b%b expected owner %0d", i, bus.gnt1, bus.gnt0, m_owner);
            end
            checks++;
            if (bus.mux_sel !== 1'(m_sel) || bus.out_vld !== 1'(m_vld) || bus.out_src !== 1'(m_src)) begin
                errors++;
                $display("FAIL rand_tag @%0d: got sel=%b vld=%b src=%b expected %0d %0d %0d",
                         i, bus.mux_sel, bus.out_vld, bus.out_src, m_sel, m_vld, m_src);
            end
            checks++;
            if (bus.mux_in0 !== (cur_d0 && m_owner == 0) || bus.mux_in1 !== (cur_d1 && m_owner == 1)) begin
                errors++;
                $display("FAIL rand_in @%0d: got in0=%b in1=%b", i, bus.mux_in0, bus.mux_in1);
            end
            checks++;
            if (int'(bus.gnt0_cnt) != (STATS ? m_cnt0 : 0) || int'(bus.gnt1_cnt) != (STATS ? m_cnt1 : 0)) begin
                errors++;
                $display("FAIL rand_cnt @%0d: got %0d %0d expected %0d %0d", i,
                         bus.gnt0_cnt, bus.gnt1_cnt, STATS ? m_cnt0 : 0, STATS ? m_cnt1 : 0);
            end
        end
    endtask

    initial begin
        nreset   = 1'b1;
        bus.req0 = 1'b0;
        bus.dat0 = 1'b0;
        bus.req1 = 1'b0;
        bus.dat1 = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_handover();
        test_reset_mid();
        test_stats();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
